// File: rtl/add_seq_pkg.sv
// Shared definitions for the byte-serial multiword adder: slice width and FSM encoding.
package add_seq_pkg;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/adder8bit.sv
// 8-bit ripple adder slice with carry in and carry out.
module adder8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] result,
   output logic       cout
);
   assign {cout, result} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract built from one 8-bit slice, stepped LSB byte first with a
// registered inter-byte carry; operands and results move over valid/ready handshakes.
module multiword_add_sequencer
   import add_seq_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [BYTE_W*WORDS-1:0] a,
   input  logic [BYTE_W*WORDS-1:0] b,
   input  logic                  cin,
   input  logic                  sub,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [BYTE_W*WORDS-1:0] result,
   output logic                  cout,
   output logic                  overflow,
   output logic                  busy
);
   localparam int W  = BYTE_W * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   state_t            state;
   logic [IW-1:0]     idx;
   logic              carry;
   logic [W-1:0]      a_r;
   logic [W-1:0]      b_r;
   logic [BYTE_W-1:0] s_byte;
   logic              s_cout;

   adder8bit u_slice (
      .a      (a_r[idx*BYTE_W +: BYTE_W]),
      .b      (b_r[idx*BYTE_W +: BYTE_W]),
      .cin    (carry),
      .result (s_byte),
      .cout   (s_cout)
   );

   // Subtraction is folded in at capture: b is stored inverted and the carry seeded to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         carry       <= 1'b0;
         a_r         <= '0;
         b_r         <= '0;
         result      <= '0;
         cout        <= 1'b0;
         overflow    <= 1'b0;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
         start_ready <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_valid) begin
                  a_r         <= a;
                  b_r         <= sub ? ~b : b;
                  carry       <= sub ? 1'b1 : cin;
                  idx         <= '0;
                  result      <= '0;
                  state       <= ST_RUN;
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            ST_RUN: begin
               result[idx*BYTE_W +: BYTE_W] <= s_byte;
               carry                        <= s_cout;
               if (idx == LAST) begin
                  cout      <= s_cout;
                  overflow  <= (a_r[W-1] ~^ b_r[W-1]) & (a_r[W-1] ^ s_byte[BYTE_W-1]);
                  state     <= ST_DONE;
                  res_valid <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  state       <= ST_IDLE;
                  res_valid   <= 1'b0;
                  busy        <= 1'b0;
                  start_ready <= 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               res_valid   <= 1'b0;
               busy        <= 1'b0;
               start_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for the byte-serial multiword adder (WORDS=4, 32-bit operands).
module tb_multiword_add_sequencer;
   localparam int WORDS = 4;
   localparam int W     = 8 * WORDS;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_valid = 1'b0;
   logic         start_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;
   logic         busy;

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         o;
   } exp_t;

   exp_t sbq[$];
   int   compared = 0;
   int   mismatched = 0;
   int   cyc = 0;

   multiword_add_sequencer #(.WORDS(WORDS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .cin         (cin),
      .sub         (sub),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .result      (result),
      .cout        (cout),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                  input logic ci, input logic sb);
      logic [W:0]   s;
      logic [W-1:0] bx;
      exp_t         e;
      bx  = sb ? ~bb : bb;
      s   = {1'b0, aa} + {1'b0, bx} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
      e.r = s[W-1:0];
      e.c = s[W];
      e.o = (aa[W-1] == bx[W-1]) && (s[W-1] != aa[W-1]);
      return e;
   endfunction

   // Expected value is queued up front; returns at the falling edge after the accept edge.
   task automatic start_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci,
                           input logic sb, output int acc_cyc, output bit ok);
      ok = 0;
      acc_cyc = 0;
      sbq.push_back(model(aa, bb, ci, sb));
      @(negedge clk);
      a = aa; b = bb; cin = ci; sub = sb; start_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (start_ready) begin
            @(posedge clk);
            @(negedge clk);
            acc_cyc = cyc;
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      start_valid = 1'b0;
   endtask

   task automatic wait_res(input int budget, output bit ok, output int seen_cyc,
                           output logic [W-1:0] r, output logic c, output logic o);
      ok = 0; seen_cyc = 0; r = 'x; c = 1'bx; o = 1'bx;
      for (int i = 0; i < budget; i++) begin
         if (res_valid) begin
            ok = 1; seen_cyc = cyc; r = result; c = cout; o = overflow;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic consume();
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if (result !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_data: got r=%h c=%b o=%b want r=0 c=0 o=0", result, cout, overflow);
      end
      compared++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_ctrl: got rv=%b busy=%b sr=%b want rv=0 busy=0 sr=1",
                  res_valid, busy, start_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_carry();
      int t, tl; bit ok; logic [W-1:0] r; logic c, o; exp_t e;
      start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, t, ok);
      compared++;
      if (!ok || start_ready !== 1'b0 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL carry_accept: got ok=%b sr=%b busy=%b want ok=1 sr=0 busy=1", ok, start_ready, busy);
      end
      wait_res(12, ok, tl, r, c, o);
      e = sbq.pop_front();
      compared++;
      if (!ok || r !== e.r || c !== e.c || o !== e.o) begin
         mismatched++;
         $display("FAIL carry_sb: got ok=%b r=%h c=%b o=%b want r=%h c=%b o=%b", ok, r, c, o, e.r, e.c, e.o);
      end
      compared++;
      if (r !== 32'h0000_0000 || c !== 1'b1 || o !== 1'b0) begin
         mismatched++;
         $display("FAIL carry_value: got r=%h c=%b o=%b want r=00000000 c=1 o=0", r, c, o);
      end
      compared++;
      if (tl - t != WORDS) begin
         mismatched++;
         $display("FAIL carry_latency: got %0d want %0d", tl - t, WORDS);
      end
      consume();
   endtask

   task automatic test_overflow();
      int t, tl; bit ok; logic [W-1:0] r; logic c, o; exp_t e;
      start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, t, ok);
      wait_res(12, ok, tl, r, c, o);
      e = sbq.pop_front();
      compared++;
      if (!ok || r !== e.r || c !== e.c || o !== e.o) begin
         mismatched++;
         $display("FAIL ovf_sb: got ok=%b r=%h c=%b o=%b want r=%h c=%b o=%b", ok, r, c, o, e.r, e.c, e.o);
      end
      compared++;
      if (r !== 32'h8000_0000 || c !== 1'b0 || o !== 1'b1) begin
         mismatched++;
         $display("FAIL ovf_value: got r=%h c=%b o=%b want r=80000000 c=0 o=1", r, c, o);
      end
      consume();
   endtask

   task automatic test_sub();
      int t, tl; bit ok; logic [W-1:0] r; logic c, o; exp_t e;
      start_op(32'd5, 32'd7, 1'b1, 1'b1, t, ok);
      wait_res(12, ok, tl, r, c, o);
      e = sbq.pop_front();
      compared++;
      if (!ok || r !== e.r || c !== e.c || o !== e.o || r !== 32'hFFFF_FFFE || c !== 1'b0 || o !== 1'b0) begin
         mismatched++;
         $display("FAIL sub_5m7: got ok=%b r=%h c=%b o=%b want r=fffffffe c=0 o=0", ok, r, c, o);
      end
      consume();
      start_op(32'd7, 32'd5, 1'b0, 1'b1, t, ok);
      wait_res(12, ok, tl, r, c, o);
      e = sbq.pop_front();
      compared++;
      if (!ok || r !== e.r || c !== e.c || o !== e.o || r !== 32'd2 || c !== 1'b1) begin
         mismatched++;
         $display("FAIL sub_7m5: got ok=%b r=%h c=%b o=%b want r=00000002 c=1 o=0", ok, r, c, o);
      end
      consume();
   endtask

   task automatic test_backpressure();
      int t, tl; bit ok; logic [W-1:0] r; logic c, o; exp_t e;
      start_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, t, ok);
      wait_res(12, ok, tl, r, c, o);
      e = sbq.pop_front();
      compared++;
      if (!ok || r !== e.r || c !== e.c || o !== e.o) begin
         mismatched++;
         $display("FAIL bp_sb: got ok=%b r=%h c=%b o=%b want r=%h c=%b o=%b", ok, r, c, o, e.r, e.c, e.o);
      end
      a = 32'hAAAA_AAAA; b = 32'h5555_5555; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         compared++;
         if (res_valid !== 1'b1 || result !== r || cout !== c || overflow !== o || start_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_hold%0d: got rv=%b r=%h sr=%b want rv=1 r=%h sr=0", i, res_valid, result, start_ready, r);
         end
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
      #1;
      compared++;
      if (start_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL bp_same_cycle: got sr=%b want sr=0", start_ready);
      end
      @(posedge clk);
      #1;
      compared++;
      if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL bp_release: got rv=%b sr=%b busy=%b want rv=0 sr=1 busy=0", res_valid, start_ready, busy);
      end
      res_ready = 1'b0;
      repeat (6) @(negedge clk);
      compared++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL bp_ignored_start: got rv=%b busy=%b want rv=0 busy=0", res_valid, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int t, tl; bit ok; logic [W-1:0] r; logic c, o; exp_t e;
      start_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, t, ok);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      void'(sbq.pop_back());
      compared++;
      if (result !== '0 || cout !== 1'b0 || overflow !== 1'b0 || res_valid !== 1'b0 ||
          busy !== 1'b0 || start_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL midrun_reset: got r=%h c=%b o=%b rv=%b busy=%b sr=%b want r=0 c=0 o=0 rv=0 busy=0 sr=1",
                  result, cout, overflow, res_valid, busy, start_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, t, ok);
      wait_res(12, ok, tl, r, c, o);
      e = sbq.pop_front();
      compared++;
      if (!ok || r !== e.r || c !== e.c || r !== 32'h0000_0030 || c !== 1'b0) begin
         mismatched++;
         $display("FAIL midrun_next: got ok=%b r=%h c=%b want r=00000030 c=0", ok, r, c);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ta[2], tb_[2];
      logic         tci[2], tsb[2];
      int           acc_c[2];
      int           nacc, got;
      bit           will_accept;
      exp_t         e;
      ta[0] = 32'h89AB_CDEF; tb_[0] = 32'h7654_3210; tci[0] = 1'b1; tsb[0] = 1'b0;
      ta[1] = 32'h0000_0003; tb_[1] = 32'h0000_0009; tci[1] = 1'b0; tsb[1] = 1'b1;
      acc_c[0] = 0; acc_c[1] = 0; nacc = 0; got = 0;
      @(negedge clk);
      res_ready = 1'b1;
      a = ta[0]; b = tb_[0]; cin = tci[0]; sub = tsb[0]; start_valid = 1'b1;
      for (int i = 0; i < 60 && got < 2; i++) begin
         if (res_valid) begin
            e = (sbq.size() > 0) ? sbq.pop_front() : '{r: 'x, c: 1'bx, o: 1'bx};
            compared++;
            if (result !== e.r || cout !== e.c || overflow !== e.o) begin
               mismatched++;
               $display("FAIL b2b_res%0d: got r=%h c=%b o=%b want r=%h c=%b o=%b",
                        got, result, cout, overflow, e.r, e.c, e.o);
            end
            got++;
         end
         will_accept = start_valid && start_ready && nacc < 2;
         if (will_accept) begin
            sbq.push_back(model(a, b, cin, sub));
            acc_c[nacc] = cyc;
            nacc++;
         end
         @(negedge clk);
         if (will_accept) begin
            if (nacc < 2) begin
               a = ta[nacc]; b = tb_[nacc]; cin = tci[nacc]; sub = tsb[nacc];
            end else begin
               start_valid = 1'b0;
            end
         end
      end
      start_valid = 1'b0;
      res_ready = 1'b0;
      compared++;
      if (got != 2 || nacc != 2) begin
         mismatched++;
         $display("FAIL b2b_count: got results=%0d accepts=%0d want 2 and 2", got, nacc);
      end
      compared++;
      if (acc_c[1] - acc_c[0] < WORDS + 1) begin
         mismatched++;
         $display("FAIL b2b_spacing: got %0d cycles want >= %0d", acc_c[1] - acc_c[0], WORDS + 1);
      end
   endtask

   initial begin
      test_reset();
      test_carry();
      test_overflow();
      test_sub();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end
endmodule
